// File: rtl/dmem_lsu.sv
// Load/store unit between the core memory stage and a word-organised data RAM.
// Misaligned accesses are split into two aligned word accesses; all outputs are registered.
module dmem_lsu #(
    parameter int unsigned ADDR_W = 14
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [2:0]        req_funct3,
    input  logic [31:0]       req_addr,
    input  logic [31:0]       req_wdata,
    output logic              resp_valid,
    output logic              resp_err,
    output logic [31:0]       resp_rdata,
    output logic              mem_en,
    output logic [3:0]        mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_din,
    input  logic [31:0]       mem_dout
);

    typedef enum logic [1:0] {IDLE, ACC1, ACC2, RESP} state_t;

    state_t      state;
    logic        l_we;
    logic [2:0]  l_funct3;
    logic [1:0]  l_off;
    logic        l_split;
    logic [3:0]  hi_we;
    logic [31:0] hi_din;
    logic [31:0] lo_word;

    logic [2:0]  size;
    logic [1:0]  off;
    logic        illegal;
    logic        range_err;
    logic        split;
    logic [7:0]  mask;
    logic [63:0] store_d;

    always_comb begin
        off = req_addr[1:0];
        case (req_funct3[1:0])
            2'b00:   size = 3'd1;
            2'b01:   size = 3'd2;
            default: size = 3'd4;
        endcase
        illegal = (req_funct3 == 3'b011) || (req_funct3[2:1] == 2'b11) ||
                  (req_we && req_funct3[2]);
        // One 33-bit compare covers both high address bits and running off the top
        range_err = ({1'b0, req_addr} + {30'b0, size}) > (33'd1 << ADDR_W);
        split     = ({1'b0, off} + size) > 3'd4;
        mask      = ((8'd1 << size) - 8'd1) << off;
        store_d   = {32'b0, req_wdata} << {off, 3'b000};
    end

    function automatic logic [31:0] extract(input logic [31:0] hi, input logic [31:0] lo,
                                            input logic [1:0] sh, input logic [2:0] f3);
        logic [31:0] r;
        r = 32'({hi, lo} >> {sh, 3'b000});
        case (f3)
            3'b000:  return {{24{r[7]}}, r[7:0]};
            3'b001:  return {{16{r[15]}}, r[15:0]};
            3'b100:  return {24'b0, r[7:0]};
            3'b101:  return {16'b0, r[15:0]};
            default: return r;
        endcase
    endfunction

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            req_ready  <= 1'b1;
            resp_valid <= 1'b0;
            resp_err   <= 1'b0;
            resp_rdata <= '0;
            mem_en     <= 1'b0;
            mem_we     <= '0;
            mem_addr   <= '0;
            mem_din    <= '0;
            l_we       <= 1'b0;
            l_funct3   <= '0;
            l_off      <= '0;
            l_split    <= 1'b0;
            hi_we      <= '0;
            hi_din     <= '0;
            lo_word    <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (req_valid) begin
                        req_ready <= 1'b0;
                        l_we      <= req_we;
                        l_funct3  <= req_funct3;
                        l_off     <= off;
                        l_split   <= split;
                        hi_we     <= req_we ? mask[7:4] : 4'b0;
                        hi_din    <= req_we ? store_d[63:32] : 32'b0;
                        if (illegal || range_err) begin
                            state      <= RESP;
                            resp_valid <= 1'b1;
                            resp_err   <= 1'b1;
                            resp_rdata <= '0;
                        end else begin
                            state    <= ACC1;
                            mem_en   <= 1'b1;
                            mem_addr <= {req_addr[ADDR_W-1:2], 2'b00};
                            mem_we   <= req_we ? mask[3:0] : 4'b0;
                            mem_din  <= req_we ? store_d[31:0] : 32'b0;
                        end
                    end
                end
                ACC1: begin
                    lo_word <= mem_dout;
                    if (l_split) begin
                        state    <= ACC2;
                        mem_addr <= mem_addr + ADDR_W'(4);
                        mem_we   <= hi_we;
                        mem_din  <= hi_din;
                    end else begin
                        state      <= RESP;
                        mem_en     <= 1'b0;
                        mem_we     <= '0;
                        mem_din    <= '0;
                        resp_valid <= 1'b1;
                        resp_err   <= 1'b0;
                        resp_rdata <= l_we ? 32'b0 : extract(32'b0, mem_dout, l_off, l_funct3);
                    end
                end
                ACC2: begin
                    state      <= RESP;
                    mem_en     <= 1'b0;
                    mem_we     <= '0;
                    mem_din    <= '0;
                    resp_valid <= 1'b1;
                    resp_err   <= 1'b0;
                    resp_rdata <= l_we ? 32'b0 : extract(mem_dout, lo_word, l_off, l_funct3);
                end
                RESP: begin
                    state      <= IDLE;
                    req_ready  <= 1'b1;
                    resp_valid <= 1'b0;
                    resp_err   <= 1'b0;
                    resp_rdata <= '0;
                end
            endcase
        end
    end

endmodule
